// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding, opcode
// constants, the default reset vector and the one/two-word instruction classifier.
package ifu_pkg;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0020;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_LDD  = 5'b00100;
  localparam logic [4:0] OP_LDM  = 5'b00101;
  localparam logic [4:0] OP_IADD = 5'b11010;

  typedef enum logic [1:0] {
    StWaitLoad,
    StFetchW1,
    StFetchW2
  } ifu_state_e;

  // LDM and IADD carry a 16-bit immediate in the following word.
  function automatic logic is_two_word(input logic [15:0] w);
    return (w[15:11] == OP_LDM) || (w[15:11] == OP_IADD);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the fetch unit.
//  load_busy               loader owns imem, no reads allowed
//  imem_rd_en/addr/rdata   instruction-memory read port (data one cycle after rd_en)
//  stall                   decode cannot accept
//  redirect_en/pc          taken branch / jump
//  instr_valid/instr/imm/instr_pc  assembled instruction towards decode
// master: fetch unit side.  slave: memory / loader / decode side.
interface instr_fetch_unit_if #(
  parameter int unsigned AW = 32
);
  logic          load_busy;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          stall;
  logic          redirect_en;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic [15:0]   instr;
  logic [15:0]   imm;
  logic [AW-1:0] instr_pc;

  modport master (
    input  load_busy, imem_rdata, stall, redirect_en, redirect_pc,
    output imem_rd_en, imem_addr, instr_valid, instr, imm, instr_pc
  );

  modport slave (
    output load_busy, imem_rdata, stall, redirect_en, redirect_pc,
    input  imem_rd_en, imem_addr, instr_valid, instr, imm, instr_pc
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a returned instruction word and its address.
//  i_clk, i_rst_n   clock, asynchronous active-low reset
//  i_push           capture i_data/i_pc, set full
//  i_pop            release the entry
//  i_flush          drop the entry (wins over push/pop)
//  o_full           entry valid
//  o_data, o_pc     stored word and its address
module fetch_skid_buf #(
  parameter int unsigned AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [15:0]   i_data,
  input  logic [AW-1:0] i_pc,
  output logic          o_full,
  output logic [15:0]   o_data,
  output logic [AW-1:0] o_pc
);

  logic          r_full;
  logic [15:0]   r_data;
  logic [AW-1:0] r_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_pc   <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_push) begin
      r_full <= 1'b1;
      r_data <= i_data;
      r_pc   <= i_pc;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;
  assign o_pc   = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads 16-bit words from imem once the loader releases it,
// assembles one- or two-word instructions and hands them to decode with a
// valid/stall handshake. Redirects flush and refetch from a new pc.
//  i_clk, i_rst_n   clock, asynchronous active-low reset
//  io_bus           master side of instr_fetch_unit_if (imem port, loader, decode)
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEFAULT)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  instr_fetch_unit_if.master io_bus
);

  ifu_state_e    r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic          r_infl, w_infl_nxt;
  logic [AW-1:0] r_infl_pc, w_infl_pc_nxt;
  logic [15:0]   r_pend, w_pend_nxt;
  logic [AW-1:0] r_pend_pc, w_pend_pc_nxt;
  logic          r_valid, w_valid_nxt;
  logic [15:0]   r_instr, w_instr_nxt;
  logic [15:0]   r_imm, w_imm_nxt;
  logic [AW-1:0] r_ipc, w_ipc_nxt;

  logic          w_rd_en;
  logic          w_slot_free;
  logic          w_have;
  logic [15:0]   w_word;
  logic [AW-1:0] w_word_pc;
  logic          w_skid_push, w_skid_pop, w_skid_flush, w_skid_full;
  logic [15:0]   w_skid_data;
  logic [AW-1:0] w_skid_pc;

  fetch_skid_buf #(
    .AW (AW)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_skid_push),
    .i_pop   (w_skid_pop),
    .i_flush (w_skid_flush),
    .i_data  (io_bus.imem_rdata),
    .i_pc    (r_infl_pc),
    .o_full  (w_skid_full),
    .o_data  (w_skid_data),
    .o_pc    (w_skid_pc)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_infl_nxt    = 1'b0;
    w_infl_pc_nxt = r_infl_pc;
    w_pend_nxt    = r_pend;
    w_pend_pc_nxt = r_pend_pc;
    w_valid_nxt   = r_valid;
    w_instr_nxt   = r_instr;
    w_imm_nxt     = r_imm;
    w_ipc_nxt     = r_ipc;
    w_rd_en       = 1'b0;
    w_skid_push   = 1'b0;
    w_skid_pop    = 1'b0;
    w_skid_flush  = 1'b0;
    // Output register can take a new instruction this cycle.
    w_slot_free   = !r_valid || !io_bus.stall;
    // A word from the skid always precedes fresh return data; reads are never issued
    // while the skid is full, so both cannot be present in the same cycle.
    w_have        = w_skid_full || r_infl;
    w_word        = w_skid_full ? w_skid_data : io_bus.imem_rdata;
    w_word_pc     = w_skid_full ? w_skid_pc : r_infl_pc;

    if (io_bus.load_busy) begin
      // In-flight data is dropped by leaving w_infl_nxt low.
      w_state_nxt  = StWaitLoad;
      w_pc_nxt     = RESET_VEC;
      w_valid_nxt  = 1'b0;
      w_skid_flush = 1'b1;
    end else if (io_bus.redirect_en) begin
      w_state_nxt  = StFetchW1;
      w_pc_nxt     = io_bus.redirect_pc;
      w_valid_nxt  = 1'b0;
      w_skid_flush = 1'b1;
    end else if (r_state == StWaitLoad) begin
      w_state_nxt = StFetchW1;
    end else begin
      if (r_valid && !io_bus.stall) begin
        w_valid_nxt = 1'b0;
      end
      if (w_have && !w_slot_free) begin
        w_skid_push = r_infl && !w_skid_full;
      end else if (w_have) begin
        w_skid_pop = w_skid_full;
        case (r_state)
          StFetchW1: begin
            if (is_two_word(w_word)) begin
              w_pend_nxt    = w_word;
              w_pend_pc_nxt = w_word_pc;
              w_state_nxt   = StFetchW2;
            end else begin
              w_instr_nxt = w_word;
              w_imm_nxt   = 16'h0000;
              w_ipc_nxt   = w_word_pc;
              w_valid_nxt = 1'b1;
            end
          end
          StFetchW2: begin
            w_instr_nxt = r_pend;
            w_imm_nxt   = w_word;
            w_ipc_nxt   = r_pend_pc;
            w_valid_nxt = 1'b1;
            w_state_nxt = StFetchW1;
          end
          default: ;
        endcase
      end
      w_rd_en = !w_skid_full && w_slot_free;
      if (w_rd_en) begin
        w_pc_nxt      = r_pc + AW'(1);
        w_infl_nxt    = 1'b1;
        w_infl_pc_nxt = r_pc;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StWaitLoad;
      r_pc      <= RESET_VEC;
      r_infl    <= 1'b0;
      r_infl_pc <= '0;
      r_pend    <= '0;
      r_pend_pc <= '0;
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_imm     <= '0;
      r_ipc     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_infl    <= w_infl_nxt;
      r_infl_pc <= w_infl_pc_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_pc <= w_pend_pc_nxt;
      r_valid   <= w_valid_nxt;
      r_instr   <= w_instr_nxt;
      r_imm     <= w_imm_nxt;
      r_ipc     <= w_ipc_nxt;
    end
  end

  assign io_bus.imem_rd_en  = w_rd_en;
  assign io_bus.imem_addr   = r_pc;
  assign io_bus.instr_valid = r_valid;
  assign io_bus.instr       = r_instr;
  assign io_bus.imm         = r_imm;
  assign io_bus.instr_pc    = r_ipc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then
// randomized stall/redirect/load traffic checked against a program-order model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0020;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.AW(32)) bus ();

  instr_fetch_unit #(
    .AW        (32),
    .RESET_VEC (RV)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus.master)
  );

  logic [15:0] mem [256];
  int n_checks = 0;
  int n_errs = 0;
  int n_xfer = 0;

  // Instruction memory: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr[7:0]];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit two_word(input logic [15:0] w);
    return (w[15:11] == 5'b00101) || (w[15:11] == 5'b11010);
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(3) == 0) w[15:11] = ($urandom_range(1) == 0) ? 5'b00101 : 5'b11010;
    return w;
  endfunction

  // Program-order model: each accepted instruction must be the next one in memory.
  logic [31:0] exp_pc = RV;
  bit          hold_ok = 0;
  logic [32:0] prev_vii;
  logic [31:0] prev_pc;
  int          idle = 0;

  always @(negedge clk) begin
    logic [15:0] w;
    logic [7:0]  nx;
    if (!rst_n) begin
      exp_pc = RV; hold_ok = 0; idle = 0;
    end else if (bus.load_busy) begin
      check("rd_en_while_busy", bus.imem_rd_en, 0);
      exp_pc = RV; hold_ok = 0; idle = 0;
    end else if (bus.redirect_en) begin
      exp_pc = bus.redirect_pc; hold_ok = 0; idle = 0;
    end else begin
      if (hold_ok) begin
        check("stall_hold_data", {bus.instr_valid, bus.instr, bus.imm}, prev_vii);
        check("stall_hold_pc", bus.instr_pc, prev_pc);
      end
      if (bus.instr_valid && !bus.stall) begin
        w  = mem[exp_pc[7:0]];
        nx = exp_pc[7:0] + 8'd1;
        check("xfer_pc", bus.instr_pc, exp_pc);
        check("xfer_instr", bus.instr, w);
        check("xfer_imm", bus.imm, two_word(w) ? mem[nx] : 16'h0000);
        exp_pc = exp_pc + (two_word(w) ? 32'd2 : 32'd1);
        n_xfer++;
        idle = 0;
      end else if (!bus.stall) begin
        idle++;
        if (idle > 10) begin
          check("progress_gap", idle, 10);
          idle = 0;
        end
      end
      hold_ok  = bus.instr_valid && bus.stall;
      prev_vii = {bus.instr_valid, bus.instr, bus.imm};
      prev_pc  = bus.instr_pc;
    end
  end

  // Caller sits at posedge+#1; returns at posedge+#1 with load_busy just dropped.
  task automatic load_prog(input int kind, input int hold);
    bus.load_busy = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = (kind == 3) ? rand_word() : (16'h8000 | 16'(a));
    if (kind == 0) begin mem[8'h20] = 16'hC95F; mem[8'h21] = 16'h639F; mem[8'h22] = 16'h1F3D; end
    if (kind == 1) begin mem[8'h20] = 16'h2800; mem[8'h21] = 16'hBEEF; end
    repeat (hold) begin @(posedge clk); #1; end
    bus.load_busy = 1'b0;
  endtask

  task automatic expect_xfer(input string name, input logic [31:0] pc, input logic [15:0] ins,
                             input logic [15:0] im);
    bit found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.instr_valid && !bus.stall) begin
        found = 1;
        check({name, "_pc"}, bus.instr_pc, pc);
        check({name, "_instr"}, bus.instr, ins);
        check({name, "_imm"}, bus.imm, im);
      end
    end
    if (!found) check({name, "_found"}, found, 1);
  endtask

  task automatic chk_out(input string name, input bit v, input logic [15:0] ins,
                         input logic [15:0] im, input logic [31:0] pc);
    check({name, "_valid"}, bus.instr_valid, v);
    check({name, "_instr"}, bus.instr, ins);
    check({name, "_imm"}, bus.imm, im);
    check({name, "_pc"}, bus.instr_pc, pc);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int busy_left;
    bus.load_busy = 1'b1; bus.stall = 1'b0; bus.redirect_en = 1'b0;
    bus.redirect_pc = '0; bus.imem_rdata = '0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;

    // 1: reset values, load window, first read and first valid latency
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("t1_reset", 0, 16'h0, 16'h0, 32'h0);
    check("t1_reset_rd_en", bus.imem_rd_en, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    load_prog(0, 5);
    @(negedge clk); check("t1_wait_rd_en", bus.imem_rd_en, 0);
    @(negedge clk); check("t1_first_rd_en", bus.imem_rd_en, 1);
    check("t1_first_addr", bus.imem_addr, RV);
    check("t1_e0_valid", bus.instr_valid, 0);
    @(negedge clk); check("t1_e1_valid", bus.instr_valid, 0);
    // 2: three one-word instructions back to back
    @(negedge clk); chk_out("t2_a", 1, 16'hC95F, 16'h0, 32'h20);
    @(negedge clk); chk_out("t2_b", 1, 16'h639F, 16'h0, 32'h21);
    @(negedge clk); chk_out("t2_c", 1, 16'h1F3D, 16'h0, 32'h22);

    // 3: two-word LDM
    @(posedge clk); #1; load_prog(1, 2);
    repeat (3) @(negedge clk);
    @(negedge clk); check("t3_e2_valid", bus.instr_valid, 0);
    @(negedge clk); chk_out("t3_ldm", 1, 16'h2800, 16'hBEEF, 32'h20);
    @(negedge clk); chk_out("t3_next", 1, 16'h8022, 16'h0, 32'h22);

    // 4: three-cycle stall with a word landing in the skid
    @(posedge clk); #1; load_prog(2, 1);
    repeat (3) @(negedge clk);
    @(negedge clk); chk_out("t4_first", 1, 16'h8020, 16'h0, 32'h20);
    @(posedge clk); #1; bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk_out("t4_stalled", 1, 16'h8021, 16'h0, 32'h21);
      if (i < 2) @(posedge clk);
    end
    @(posedge clk); #1; bus.stall = 1'b0;
    expect_xfer("t4_x21", 32'h21, 16'h8021, 16'h0);
    expect_xfer("t4_x22", 32'h22, 16'h8022, 16'h0);
    expect_xfer("t4_x23", 32'h23, 16'h8023, 16'h0);

    // 5: redirect while the 0x23 read is returning
    @(posedge clk); #1; load_prog(2, 1);
    repeat (5) @(posedge clk);
    #1; bus.redirect_en = 1'b1; bus.redirect_pc = 32'h40;
    @(posedge clk); #1; bus.redirect_en = 1'b0;
    @(negedge clk);
    check("t5_rd_en", bus.imem_rd_en, 1);
    check("t5_addr", bus.imem_addr, 32'h40);
    check("t5_valid_dropped", bus.instr_valid, 0);
    expect_xfer("t5_target", 32'h40, 16'h8040, 16'h0);

    // 6: load_busy pulse mid-fetch, then asynchronous reset during a stall
    @(posedge clk); #1; load_prog(2, 1);
    repeat (4) @(posedge clk);
    #1; bus.load_busy = 1'b1;
    @(posedge clk); #1; bus.load_busy = 1'b0;
    expect_xfer("t6_restart", 32'h20, 16'h8020, 16'h0);
    @(posedge clk); #1; bus.stall = 1'b1;
    @(negedge clk); check("t6_pre_valid", bus.instr_valid, 1);
    #2; rst_n = 1'b0;
    #1;
    chk_out("t6_async", 0, 16'h0, 16'h0, 32'h0);
    check("t6_async_rd_en", bus.imem_rd_en, 0);
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1; bus.stall = 1'b0;
    expect_xfer("t6_after_reset", 32'h20, 16'h8020, 16'h0);

    // pc wrap at the top of the address space
    @(posedge clk); #1; bus.redirect_en = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
    @(posedge clk); #1; bus.redirect_en = 1'b0;
    expect_xfer("wrap_top", 32'hFFFF_FFFF, 16'h80FF, 16'h0);
    expect_xfer("wrap_zero", 32'h0, 16'h8000, 16'h0);

    // Random traffic against the program-order model
    @(posedge clk); #1; load_prog(3, 2);
    n_xfer = 0;
    busy_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.stall = ($urandom_range(99) < 30);
      bus.redirect_en = 1'b0;
      if (busy_left != 0) begin
        busy_left--;
        bus.load_busy = 1'b1;
      end else begin
        bus.load_busy = 1'b0;
        r = $urandom_range(999);
        if (r < 8) begin
          bus.load_busy = 1'b1;
          busy_left = $urandom_range(2);
          for (int k = 0; k < 16; k++) mem[$urandom_range(255)] = rand_word();
        end else if (r < 50) begin
          bus.redirect_en = 1'b1;
          bus.redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15)
                                                     : $urandom_range(255);
        end
      end
    end
    @(posedge clk); #1; bus.stall = 1'b0; bus.load_busy = 1'b0; bus.redirect_en = 1'b0;
    repeat (5) @(posedge clk);
    check("random_progress", n_xfer >= 300, 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
